exception_sequencer: RTL

- Multicycle FSM that owns the memory-address mux select and write-enable whenever the CPU takes an exception (invalid opcode, ALU overflow, divide-by-zero).
- When idle, it passes the main control unit's address select and write-enable straight through to the mux and memory.
- On an exception it stalls the main control and saves EPC. It then drives the vector address (253/254/255), waits for memory, and loads PC with the zero-extended handler byte.

---
 rtl/exc_pkg.sv | 32 +++
 rtl/exc_priority_enc.sv | 22 ++
 rtl/exception_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared encodings for the exception sequencer and the address mux: FSM states,
// cause codes and address-select values.
package exc_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SAVE_EPC = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_LOAD_PC  = 2'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE   = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;
    localparam logic [1:0] CAUSE_DIV0     = 2'b11;

    localparam logic [2:0] ADDR_SEL_ALU_RESULT = 3'b000;
    localparam logic [2:0] ADDR_SEL_ALUOUT     = 3'b001;
    localparam logic [2:0] ADDR_SEL_VEC_253    = 3'b010;
    localparam logic [2:0] ADDR_SEL_VEC_254    = 3'b011;
    localparam logic [2:0] ADDR_SEL_VEC_255    = 3'b100;

    typedef struct packed {
        logic       valid;
        logic [1:0] cause;
        logic [2:0] vec_sel;
    } exc_req_t;

    // EPC records the faulting instruction, one word behind the incremented PC.
    function automatic logic [31:0] epc_from_pc(input logic [31:0] pc);
        return pc - 32'd4;
    endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority encoder for the exception request lines: opcode > overflow > div0.
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic     i_exc_opcode,
    input  logic     i_exc_overflow,
    input  logic     i_exc_div0,
    output exc_req_t o_req
);

    always_comb begin
        o_req = '{valid: 1'b0, cause: CAUSE_NONE, vec_sel: ADDR_SEL_ALU_RESULT};
        if (i_exc_opcode) begin
            o_req = '{valid: 1'b1, cause: CAUSE_OPCODE, vec_sel: ADDR_SEL_VEC_253};
        end else if (i_exc_overflow) begin
            o_req = '{valid: 1'b1, cause: CAUSE_OVERFLOW, vec_sel: ADDR_SEL_VEC_254};
        end else if (i_exc_div0) begin
            o_req = '{valid: 1'b1, cause: CAUSE_DIV0, vec_sel: ADDR_SEL_VEC_255};
        end
    end

endmodule

// File: rtl/exception_sequencer.sv
// Takes over the address mux and memory write-enable while an exception is serviced:
// saves EPC, reads the handler byte from the vector slot, and loads it into PC.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [2:0]  i_ctrl_addr_sel,
    input  logic        i_ctrl_mem_wr,
    input  logic        i_exc_opcode,
    input  logic        i_exc_overflow,
    input  logic        i_exc_div0,
    input  logic [31:0] i_pc_in,
    input  logic [31:0] i_mem_data_in,
    output logic [2:0]  o_addr_sel,
    output logic        o_mem_wr,
    output logic        o_epc_load,
    output logic [31:0] o_epc_data,
    output logic        o_pc_load,
    output logic [31:0] o_pc_data,
    output logic        o_cpu_stall,
    output logic [1:0]  o_exc_cause
);

    exc_req_t    w_req;
    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_vec_sel;
    logic [1:0]  r_cause;
    logic [31:0] r_epc_data;

    exc_priority_enc u_enc (
        .i_exc_opcode   (i_exc_opcode),
        .i_exc_overflow (i_exc_overflow),
        .i_exc_div0     (i_exc_div0),
        .o_req          (w_req)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_vec_sel  <= ADDR_SEL_ALU_RESULT;
            r_cause    <= CAUSE_NONE;
            r_epc_data <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req.valid) begin
                        r_state    <= ST_SAVE_EPC;
                        r_vec_sel  <= w_req.vec_sel;
                        r_cause    <= w_req.cause;
                        r_epc_data <= epc_from_pc(i_pc_in);
                    end
                end
                ST_SAVE_EPC: begin
                    r_state <= ST_MEM_WAIT;
                    r_cnt   <= 3'(MEM_LATENCY - 1);
                end
                ST_MEM_WAIT: begin
                    if (r_cnt == 3'd0) r_state <= ST_LOAD_PC;
                    else               r_cnt   <= r_cnt - 3'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Reset forces the control outputs low combinationally so nothing leaks
    // out of an aborted sequence during the reset cycle itself.
    always_comb begin
        o_addr_sel  = r_vec_sel;
        o_mem_wr    = 1'b0;
        o_epc_load  = 1'b0;
        o_pc_load   = 1'b0;
        o_pc_data   = 32'd0;
        o_cpu_stall = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_addr_sel  = i_ctrl_addr_sel;
                o_mem_wr    = i_ctrl_mem_wr;
                o_cpu_stall = 1'b0;
            end
            ST_SAVE_EPC: o_epc_load = 1'b1;
            ST_LOAD_PC: begin
                o_pc_load = 1'b1;
                o_pc_data = {24'd0, i_mem_data_in[7:0]};
            end
            default: ;
        endcase
        if (i_reset) begin
            o_addr_sel  = ADDR_SEL_ALU_RESULT;
            o_mem_wr    = 1'b0;
            o_epc_load  = 1'b0;
            o_pc_load   = 1'b0;
            o_pc_data   = 32'd0;
            o_cpu_stall = 1'b0;
        end
    end

    assign o_epc_data  = r_epc_data;
    assign o_exc_cause = r_cause;

endmodule
